demod_arctan_prep: RTL and testbench
====================================

Name: demod_arctan_prep

Overview:
- FM demodulator front half: reads the I and Q sample FIFOs and forms the conjugate product of the current and previous samples.
- Computes the arctan-ratio numerator and denominator and pushes them into the two operand FIFOs of the downstream signed divider.
- Pushes a 2-bit quadrant code into a side FIFO for the angle-reconstruction stage after the divider.
- Three-stage pipeline with a global stall; fixed latency of 3 cycles when not stalled.

Parameters:
- WIDTH, 32: sample and operand width (signed).
- QUANT, 10: fixed-point fraction bits.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- inI_rd_en  out  1  pop I sample FIFO
- inI_empty  in  1  I FIFO empty
- inI_dout  in  WIDTH  signed I sample, Q(QUANT)
- inQ_rd_en  out  1  pop Q sample FIFO
- inQ_empty  in  1  Q FIFO empty
- inQ_dout  in  WIDTH  signed Q sample
- num_wr_en  out  1  push numerator (divider dividend FIFO)
- num_full  in  1  numerator FIFO full
- num_din  out  WIDTH  signed numerator, pre-scaled by 2^QUANT
- den_wr_en  out  1  push denominator (divider divisor FIFO)
- den_full  in  1  denominator FIFO full
- den_din  out  WIDTH  signed denominator, always >= 1
- quad_wr_en  out  1  push quadrant code
- quad_full  in  1  quadrant FIFO full
- quad_din  out  2  {imag<0, real<0}

Behaviour:
- Reset is synchronous and active-high, on clock. Reset clears all stage valids, prevI/prevQ = 0 and all pipeline data.
- Outputs during and after reset: every *_rd_en and *_wr_en = 0; num_din = 0; den_din = 0; quad_din = 0.
- Reset mid-operation: in-flight samples are discarded; no write in the cycle after reset.
- Enable: adv = !num_full && !den_full && !quad_full. All pipeline registers hold when adv = 0.
- Read: inI_rd_en = inQ_rd_en = adv && !inI_empty && !inQ_empty. Both FIFOs always pop together.
- S1 (on read): register cur = (I, Q) and prev = (prevI, prevQ); then prevI/prevQ <= I/Q. s1_valid <= read. When adv holds and there is no read, s1_valid <= 0 (bubble).
- S2 (dequantized products): each product is 2*WIDTH wide, then >>> QUANT, then truncated to WIDTH.
  - real = deq(I*prevI) + deq(Q*prevQ)
  - imag = deq(Q*prevI) - deq(I*prevQ)
  - Sums wrap modulo 2^WIDTH.
- S3:
  - abs_y = |imag| + 1.
  - If real >= 0: n = real - abs_y, d = real + abs_y. Else: n = real + abs_y, d = abs_y - real.
  - num = n << QUANT, wrapping unless the optional feature is enabled.
  - quad = {imag[WIDTH-1], real[WIDTH-1]}.
- Write: num_wr_en = den_wr_en = quad_wr_en = adv && s3_valid. The three writes are never split. Output data is registered and held while stalled.
- Latency: sample popped in cycle t is written in cycle t+3 if not stalled. Throughput is 1 sample/cycle.
- A read and a write may occur in the same cycle.
- A full output FIFO stalls reads the same cycle; no data is lost or duplicated.
- First sample after reset uses prev = (0, 0) and its result is emitted, not suppressed.
- den_din is >= 1 except on arithmetic wrap with |real| near 2^(WIDTH-1). The divider relies on this.

Optional Feature:
- Macro DEMOD_NUM_SAT_EN.
- Defined: if n exceeds the WIDTH-bit signed range after << QUANT, num_din saturates to 0x7FFFFFFF or 0x80000000 by the sign of n.
- Undefined: plain truncating shift (wrap).
- Timing and handshake are identical in both builds.

Test Plan:
- Reset, then samples (1024,0) then (0,1024) -> writes at t+3, t+4: (num -1024, den 1, quad 00) then (num -1049600, den 1025, quad 00).
- Samples (1024,0) then (-1024,0) -> second write: num -1047552, den 1025, quad 01.
- Samples (65536,0),(65536,0) -> second write: real = 2^22, den 4194305, num 0xFFFFFC00 without the macro, 0x7FFFFFFF with DEMOD_NUM_SAT_EN.
- Stream 8 samples; assert den_full for 5 cycles mid-stream -> rd_en and all wr_en low while full; 8 results in order, none lost or duplicated, num/den/quad counts equal.
- inQ_empty toggling while inI non-empty -> no single-FIFO pops; bubbles produce no writes; output sequence matches the golden model.
- Assert reset with 3 samples in flight -> no writes after reset; next sample uses prev = (0,0) (e.g. (1024,0) -> num -1024, den 1).

Source files
------------

// File: rtl/demod_arctan_prep_if.sv
// Sample-FIFO read side, divider operand FIFO write side and quadrant side FIFO
// of the FM demodulator arctan preparation stage.
interface demod_arctan_prep_if #(
    parameter int WIDTH = 32
);
    logic             inI_rd_en;
    logic             inI_empty;
    logic [WIDTH-1:0] inI_dout;
    logic             inQ_rd_en;
    logic             inQ_empty;
    logic [WIDTH-1:0] inQ_dout;
    logic             num_wr_en;
    logic             num_full;
    logic [WIDTH-1:0] num_din;
    logic             den_wr_en;
    logic             den_full;
    logic [WIDTH-1:0] den_din;
    logic             quad_wr_en;
    logic             quad_full;
    logic [1:0]       quad_din;

    modport master (
        output inI_rd_en, inQ_rd_en, num_wr_en, num_din, den_wr_en, den_din,
               quad_wr_en, quad_din,
        input  inI_empty, inI_dout, inQ_empty, inQ_dout, num_full, den_full, quad_full
    );

    modport slave (
        input  inI_rd_en, inQ_rd_en, num_wr_en, num_din, den_wr_en, den_din,
               quad_wr_en, quad_din,
        output inI_empty, inI_dout, inQ_empty, inQ_dout, num_full, den_full, quad_full
    );
endinterface

// File: rtl/demod_arctan_prep.sv
// FM demodulator front half: conjugate product of consecutive I/Q samples, arctan
// ratio operands and quadrant code; 3-stage pipeline. Macro DEMOD_NUM_SAT_EN saturates num.
module demod_arctan_prep #(
    parameter int WIDTH = 32,
    parameter int QUANT = 10
) (
    input  logic                clock,
    input  logic                reset,
    demod_arctan_prep_if.master bus
);

    localparam logic [WIDTH-1:0] ONE_C = {{(WIDTH-1){1'b0}}, 1'b1};

    function automatic logic signed [WIDTH-1:0] deq(input logic signed [WIDTH-1:0] a,
                                                    input logic signed [WIDTH-1:0] b);
        logic signed [2*WIDTH-1:0] prod;
        prod = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
        return prod[WIDTH+QUANT-1:QUANT];
    endfunction

    function automatic logic [WIDTH-1:0] scale_num(input logic signed [WIDTH-1:0] n);
`ifdef DEMOD_NUM_SAT_EN
        logic [WIDTH+QUANT-1:0] wide;
        wide = {n, {QUANT{1'b0}}};
        // In range only when every bit above the result sign matches the sign of n
        if (wide[WIDTH+QUANT-1:WIDTH-1] == {(QUANT+1){n[WIDTH-1]}}) begin
            return wide[WIDTH-1:0];
        end else if (n[WIDTH-1]) begin
            return {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            return {1'b0, {(WIDTH-1){1'b1}}};
        end
`else
        return {n[WIDTH-QUANT-1:0], {QUANT{1'b0}}};
`endif
    endfunction

    logic                    adv_s, rd_s, wr_s;
    logic                    s1_valid_q, s1_valid_d;
    logic signed [WIDTH-1:0] cur_i_q, cur_i_d, cur_q_q, cur_q_d;
    logic signed [WIDTH-1:0] prv_i_q, prv_i_d, prv_q_q, prv_q_d;
    logic signed [WIDTH-1:0] prev_i_q, prev_i_d, prev_q_q, prev_q_d;
    logic                    s2_valid_q, s2_valid_d;
    logic signed [WIDTH-1:0] re_q, re_d, im_q, im_d;
    logic                    s3_valid_q, s3_valid_d;
    logic [WIDTH-1:0]        num_q, num_d, den_q, den_d;
    logic [1:0]              quad_q, quad_d;
    logic signed [WIDTH-1:0] abs_y_s, n_s, d_s;

    // Global stall and FIFO handshakes; reset gates every pop and push
    always_comb begin
        adv_s = !(bus.num_full || bus.den_full || bus.quad_full);
        rd_s  = adv_s && !reset && !bus.inI_empty && !bus.inQ_empty;
        wr_s  = adv_s && !reset && s3_valid_q;
    end

    assign bus.inI_rd_en  = rd_s;
    assign bus.inQ_rd_en  = rd_s;
    assign bus.num_wr_en  = wr_s;
    assign bus.den_wr_en  = wr_s;
    assign bus.quad_wr_en = wr_s;
    assign bus.num_din    = num_q;
    assign bus.den_din    = den_q;
    assign bus.quad_din   = quad_q;

    // S1: capture current and previous sample on each pop
    always_comb begin
        s1_valid_d = adv_s ? rd_s : s1_valid_q;
        if (rd_s) begin
            cur_i_d  = bus.inI_dout;
            cur_q_d  = bus.inQ_dout;
            prv_i_d  = prev_i_q;
            prv_q_d  = prev_q_q;
            prev_i_d = bus.inI_dout;
            prev_q_d = bus.inQ_dout;
        end else begin
            cur_i_d  = cur_i_q;
            cur_q_d  = cur_q_q;
            prv_i_d  = prv_i_q;
            prv_q_d  = prv_q_q;
            prev_i_d = prev_i_q;
            prev_q_d = prev_q_q;
        end
    end

    // S2: conjugate product cur * conj(prev), each term dequantized before summing
    always_comb begin
        s2_valid_d = adv_s ? s1_valid_q : s2_valid_q;
        if (adv_s && s1_valid_q) begin
            re_d = deq(cur_i_q, prv_i_q) + deq(cur_q_q, prv_q_q);
            im_d = deq(cur_q_q, prv_i_q) - deq(cur_i_q, prv_q_q);
        end else begin
            re_d = re_q;
            im_d = im_q;
        end
    end

    // S3: arctan ratio operands; the +1 keeps the divisor away from zero
    always_comb begin
        abs_y_s = (im_q[WIDTH-1] ? (~im_q + ONE_C) : im_q) + ONE_C;
        if (!re_q[WIDTH-1]) begin
            n_s = re_q - abs_y_s;
            d_s = re_q + abs_y_s;
        end else begin
            n_s = re_q + abs_y_s;
            d_s = abs_y_s - re_q;
        end
        s3_valid_d = adv_s ? s2_valid_q : s3_valid_q;
        if (adv_s && s2_valid_q) begin
            num_d  = scale_num(n_s);
            den_d  = d_s;
            quad_d = {im_q[WIDTH-1], re_q[WIDTH-1]};
        end else begin
            num_d  = num_q;
            den_d  = den_q;
            quad_d = quad_q;
        end
    end

    // Pipeline registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            cur_i_q    <= '0;
            cur_q_q    <= '0;
            prv_i_q    <= '0;
            prv_q_q    <= '0;
            prev_i_q   <= '0;
            prev_q_q   <= '0;
            s2_valid_q <= 1'b0;
            re_q       <= '0;
            im_q       <= '0;
            s3_valid_q <= 1'b0;
            num_q      <= '0;
            den_q      <= '0;
            quad_q     <= 2'b00;
        end else begin
            s1_valid_q <= s1_valid_d;
            cur_i_q    <= cur_i_d;
            cur_q_q    <= cur_q_d;
            prv_i_q    <= prv_i_d;
            prv_q_q    <= prv_q_d;
            prev_i_q   <= prev_i_d;
            prev_q_q   <= prev_q_d;
            s2_valid_q <= s2_valid_d;
            re_q       <= re_d;
            im_q       <= im_d;
            s3_valid_q <= s3_valid_d;
            num_q      <= num_d;
            den_q      <= den_d;
            quad_q     <= quad_d;
        end
    end

endmodule

// File: tb/tb_demod_arctan_prep.sv
// Directed bench for demod_arctan_prep: vector table plus stall, empty-toggle and
// mid-stream reset sequences; expectations from hand values and a reference model.
module tb_demod_arctan_prep;
    localparam int W = 32;
    localparam int Q = 10;

    typedef struct {
        logic signed [31:0] i;
        logic signed [31:0] q;
        logic [31:0]        num;
        logic [31:0]        den;
        logic [1:0]         quad;
    } vec_t;

    typedef struct {
        logic [31:0] num;
        logic [31:0] den;
        logic [1:0]  quad;
        int          cyc;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    demod_arctan_prep_if #(.WIDTH(W)) bus();
    demod_arctan_prep #(.WIDTH(W), .QUANT(Q)) dut (.clock(clk), .reset(rst), .bus(bus));

    int n_chk = 0, n_fail = 0, cyc = 0;
    int n_num = 0, n_den = 0, n_quad = 0;
    logic signed [31:0] iq[$], qq[$];
    res_t expq[$], gotq[$];
    logic signed [31:0] m_pi = 32'sd0, m_pq = 32'sd0;
    bit q_block = 1'b0, lat_chk = 1'b0;
    logic num_full_f = 1'b0, den_full_f = 1'b0, quad_full_f = 1'b0;
    vec_t tbl[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic res_t model(input logic signed [31:0] i, input logic signed [31:0] q,
                                   input logic signed [31:0] pi, input logic signed [31:0] pq);
        res_t r;
        logic signed [63:0] pa, pb, pc, pd;
        logic signed [31:0] re, im, ay, n, d;
        longint nl;
        pa = i * pi;  pb = q * pq;  pc = q * pi;  pd = i * pq;
        pa = pa >>> 10; pb = pb >>> 10; pc = pc >>> 10; pd = pd >>> 10;
        re = pa[31:0] + pb[31:0];
        im = pc[31:0] - pd[31:0];
        ay = ((im < 0) ? -im : im) + 32'sd1;
        if (re >= 0) begin n = re - ay; d = re + ay; end
        else begin n = re + ay; d = ay - re; end
        nl = longint'(n) * 64'sd1024;
`ifdef DEMOD_NUM_SAT_EN
        if (nl > 64'sd2147483647) r.num = 32'h7FFFFFFF;
        else if (nl < -64'sd2147483648) r.num = 32'h80000000;
        else r.num = nl[31:0];
`else
        r.num = nl[31:0];
`endif
        r.den = d;
        r.quad = {im[31], re[31]};
        r.cyc = 0;
        return r;
    endfunction

    // One clock: drive inputs at negedge, sample and score before the next posedge
    task automatic cycle();
        logic exp_rd;
        res_t e, g;
        @(negedge clk);
        bus.inI_empty = (iq.size() == 0);
        bus.inI_dout  = (iq.size() == 0) ? 32'sd0 : iq[0];
        bus.inQ_empty = (qq.size() == 0) || q_block;
        bus.inQ_dout  = (qq.size() == 0) ? 32'sd0 : qq[0];
        bus.num_full  = num_full_f;
        bus.den_full  = den_full_f;
        bus.quad_full = quad_full_f;
        #1;
        cyc++;
        exp_rd = !rst && !num_full_f && !den_full_f && !quad_full_f
                 && !bus.inI_empty && !bus.inQ_empty;
        check("rd_en_I", {31'd0, bus.inI_rd_en}, {31'd0, exp_rd});
        check("rd_en_Q", {31'd0, bus.inQ_rd_en}, {31'd0, exp_rd});
        check("wr_den_vs_num", {31'd0, bus.den_wr_en}, {31'd0, bus.num_wr_en});
        check("wr_quad_vs_num", {31'd0, bus.quad_wr_en}, {31'd0, bus.num_wr_en});
        if (rst || num_full_f || den_full_f || quad_full_f)
            check("wr_while_blocked", {31'd0, bus.num_wr_en}, 32'd0);
        if (bus.num_wr_en) n_num++;
        if (bus.den_wr_en) n_den++;
        if (bus.quad_wr_en) n_quad++;
        if (bus.num_wr_en) begin
            g.num = bus.num_din; g.den = bus.den_din; g.quad = bus.quad_din; g.cyc = cyc;
            gotq.push_back(g);
            check("write_expected", {31'd0, expq.size() != 0}, 32'd1);
            if (expq.size() != 0) begin
                e = expq.pop_front();
                check("num", bus.num_din, e.num);
                check("den", bus.den_din, e.den);
                check("quad", {30'd0, bus.quad_din}, {30'd0, e.quad});
                if (lat_chk) check("latency", cyc - e.cyc, 32'd3);
            end
        end
        if (bus.inI_rd_en && iq.size() != 0 && qq.size() != 0) begin
            e = model(iq[0], qq[0], m_pi, m_pq);
            e.cyc = cyc;
            expq.push_back(e);
            m_pi = iq.pop_front();
            m_pq = qq.pop_front();
        end
    endtask

    task automatic apply_reset(input int n);
        rst = 1'b1;
        expq.delete();
        m_pi = 32'sd0;
        m_pq = 32'sd0;
        repeat (n) cycle();
        rst = 1'b0;
    endtask

    task automatic drain(input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            if (iq.size() == 0 && expq.size() == 0) break;
            cycle();
        end
        check("drain_timeout", {31'd0, k >= budget}, 32'd0);
    endtask

    task automatic push(input logic signed [31:0] i, input logic signed [31:0] q);
        iq.push_back(i);
        qq.push_back(q);
    endtask

    initial begin
        int base;
        rst = 1'b1;
        bus.inI_empty = 1'b1; bus.inI_dout = '0;
        bus.inQ_empty = 1'b1; bus.inQ_dout = '0;
        bus.num_full = 1'b0; bus.den_full = 1'b0; bus.quad_full = 1'b0;

        tbl[0] = '{32'sd1024,   32'sd0,     -32'sd1024,     32'd1,       2'b00};
        tbl[1] = '{32'sd0,      32'sd1024,  -32'sd1049600,  32'd1025,    2'b00};
        tbl[2] = '{32'sd1024,   32'sd0,     -32'sd1049600,  32'd1025,    2'b10};
        tbl[3] = '{-32'sd1024,  32'sd0,     -32'sd1047552,  32'd1025,    2'b01};
        tbl[4] = '{32'sd65536,  32'sd0,     -32'sd67107840, 32'd65537,   2'b01};
`ifdef DEMOD_NUM_SAT_EN
        tbl[5] = '{32'sd65536,  32'sd0,     32'h7FFFFFFF,   32'd4194305, 2'b00};
        tbl[6] = '{-32'sd65536, 32'sd0,     32'h80000000,   32'd4194305, 2'b01};
`else
        tbl[5] = '{32'sd65536,  32'sd0,     32'hFFFFFC00,   32'd4194305, 2'b00};
        tbl[6] = '{-32'sd65536, 32'sd0,     32'h00000400,   32'd4194305, 2'b01};
`endif
        tbl[7] = '{32'sd0,      -32'sd1024, -32'sd67109888, 32'd65537,   2'b00};
        tbl[8] = '{-32'sd3,     32'sd5,     -32'sd1024,     32'd9,       2'b11};
        tbl[9] = '{32'sd3,      -32'sd7,    -32'sd1024,     32'd3,       2'b01};

        // Reset state
        apply_reset(3);
        cycle();
        check("rst_num_din", bus.num_din, 32'd0);
        check("rst_den_din", bus.den_din, 32'd0);
        check("rst_quad_din", {30'd0, bus.quad_din}, 32'd0);
        check("rst_wr_en", {31'd0, bus.num_wr_en}, 32'd0);

        // Table vectors, back to back, latency checked
        gotq.delete();
        lat_chk = 1'b1;
        for (int k = 0; k < 10; k++) push(tbl[k].i, tbl[k].q);
        drain(40);
        lat_chk = 1'b0;
        check("tbl_count", gotq.size(), 32'd10);
        for (int k = 0; k < 10 && k < gotq.size(); k++) begin
            check($sformatf("tbl%0d_num", k), gotq[k].num, tbl[k].num);
            check($sformatf("tbl%0d_den", k), gotq[k].den, tbl[k].den);
            check($sformatf("tbl%0d_quad", k), {30'd0, gotq[k].quad}, {30'd0, tbl[k].quad});
        end

        // Downstream stall: den_full for 5 cycles mid-stream
        apply_reset(2);
        base = n_num;
        n_den = n_num; n_quad = n_num;
        for (int k = 0; k < 8; k++) push(k * 3000 - 7000, 5000 - k * 1700);
        for (int k = 0; k < 30; k++) begin
            den_full_f = (k >= 4 && k < 9);
            cycle();
        end
        den_full_f = 1'b0;
        check("stall_count_num", n_num - base, 32'd8);
        check("stall_count_den", n_den - base, 32'd8);
        check("stall_count_quad", n_quad - base, 32'd8);
        check("stall_leftover", expq.size(), 32'd0);

        // Q FIFO empty toggling while I has data
        base = n_num;
        for (int k = 0; k < 6; k++) push(-k * 2500 + 900, k * 4100 - 300);
        for (int k = 0; k < 40; k++) begin
            q_block = (k % 3 != 0);
            cycle();
        end
        q_block = 1'b0;
        check("toggle_count", n_num - base, 32'd6);
        check("toggle_leftover", expq.size(), 32'd0);

        // Reset with three samples in flight
        push(32'sd7000, 32'sd123);
        push(-32'sd4000, 32'sd9000);
        push(32'sd2048, -32'sd512);
        repeat (3) cycle();
        base = n_num;
        apply_reset(2);
        repeat (5) cycle();
        check("no_write_after_reset", n_num - base, 32'd0);
        gotq.delete();
        push(32'sd1024, 32'sd0);
        drain(20);
        check("post_reset_count", gotq.size(), 32'd1);
        if (gotq.size() != 0) begin
            check("post_reset_num", gotq[0].num, 32'hFFFFFC00);
            check("post_reset_den", gotq[0].den, 32'd1);
            check("post_reset_quad", {30'd0, gotq[0].quad}, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
